// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the tpu_ctrl GEMM sequencer: state encoding and parameter defaults.
package tpu_ctrl_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int ADDR_W_DEF = 8;
    localparam int DIM_W_DEF  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_DONE
    } state_e;

endpackage

// File: rtl/tpu_ctrl_xfer_cnt.sv
// Transfer-length counter with synchronous clear/increment and a flag marking the final element.
module tpu_ctrl_xfer_cnt
    import tpu_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] len_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero length has no last element, so the flag stays low.
    assign cnt_o  = cnt_q;
    assign last_o = (len_i != '0) && (cnt_q == len_i - ADDR_W'(1));

endmodule

// File: rtl/tpu_ctrl.sv
// GEMM sequencer: streams k operand words from GBUFF_A/B into the tpu, drains m results into GBUFF_OUT.
// Define TPU_CTRL_PERF_EN to add the perf_cycles_o/perf_stall_o performance counters.
module tpu_ctrl
    import tpu_ctrl_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIM_W  = DIM_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DIM_W-1:0]  m_i,
    input  logic [DIM_W-1:0]  n_i,
    input  logic [DIM_W-1:0]  k_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] gbuf_rd_idx_o,
    input  logic [WORD_W-1:0] gbuf_a_dout_i,
    input  logic [WORD_W-1:0] gbuf_b_dout_i,
    output logic              tpu_start_o,
    output logic [DIM_W-1:0]  tpu_n_o,
    output logic              tpu_in_valid_o,
    input  logic              tpu_in_ready_i,
    output logic [WORD_W-1:0] tpu_a_o,
    output logic [WORD_W-1:0] tpu_b_o,
    input  logic              tpu_out_valid_i,
    output logic              tpu_out_ready_o,
    input  logic [WORD_W-1:0] tpu_out_i,
    output logic              gbuf_o_wr_en_o,
    output logic [ADDR_W-1:0] gbuf_o_idx_o,
`ifdef TPU_CTRL_PERF_EN
    output logic [31:0]       perf_cycles_o,
    output logic [31:0]       perf_stall_o,
`endif
    output logic [WORD_W-1:0] gbuf_o_din_o
);

    state_e            state_q;
    logic [DIM_W-1:0]  m_q, n_q, k_q;
    logic              busy_q, done_q, in_valid_q, out_ready_q;
    logic              accept, rd_hs, wr_hs, rd_last, wr_last;
    logic [ADDR_W-1:0] rd_cnt, wr_cnt;

    assign accept = start_i && (state_q == ST_IDLE);
    assign rd_hs  = in_valid_q && tpu_in_ready_i;
    assign wr_hs  = out_ready_q && tpu_out_valid_i;

    // Handshake-qualified outputs are registered flags so they toggle exactly on state entry/exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            m_q         <= '0;
            n_q         <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_valid_q  <= 1'b0;
            out_ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        m_q    <= m_i;
                        n_q    <= n_i;
                        k_q    <= k_i;
                        busy_q <= 1'b1;
                        if ((m_i == '0) || (k_i == '0)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_RD;
                            in_valid_q <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (rd_hs && rd_last) begin
                        state_q    <= ST_WAIT;
                        in_valid_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    state_q     <= ST_WR;
                    out_ready_q <= 1'b1;
                end
                ST_WR: begin
                    if (wr_hs && wr_last) begin
                        state_q     <= ST_DONE;
                        out_ready_q <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    tpu_ctrl_xfer_cnt #(.ADDR_W(ADDR_W)) u_rd_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  ((state_q == ST_WAIT) || (state_q == ST_DONE)),
        .inc_i  (rd_hs),
        .len_i  (ADDR_W'(k_q)),
        .cnt_o  (rd_cnt),
        .last_o (rd_last)
    );

    tpu_ctrl_xfer_cnt #(.ADDR_W(ADDR_W)) u_wr_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == ST_DONE),
        .inc_i  (wr_hs),
        .len_i  (ADDR_W'(m_q)),
        .cnt_o  (wr_cnt),
        .last_o (wr_last)
    );

    // tpu_start is gated by rst_n so every output reads zero while reset is asserted.
    assign tpu_start_o     = accept && rst_n;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign tpu_n_o         = n_q;
    assign tpu_in_valid_o  = in_valid_q;
    assign gbuf_rd_idx_o   = in_valid_q ? rd_cnt : '0;
    assign tpu_a_o         = in_valid_q ? gbuf_a_dout_i : '0;
    assign tpu_b_o         = in_valid_q ? gbuf_b_dout_i : '0;
    assign tpu_out_ready_o = out_ready_q;
    assign gbuf_o_wr_en_o  = wr_hs;
    assign gbuf_o_idx_o    = wr_hs ? wr_cnt : '0;
    assign gbuf_o_din_o    = wr_hs ? tpu_out_i : '0;

`ifdef TPU_CTRL_PERF_EN
    logic [31:0] perf_cycles_q, perf_stall_q;
    logic        stall_now;

    assign stall_now = (in_valid_q && !tpu_in_ready_i) || (out_ready_q && !tpu_out_valid_i);

    // The acceptance cycle counts as the first job cycle; both counters hold once busy drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else if (accept) begin
            perf_cycles_q <= 32'd1;
            perf_stall_q  <= '0;
        end else if (busy_q) begin
            if (perf_cycles_q != '1) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (stall_now && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_cycles_o = perf_cycles_q;
    assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_tpu_ctrl.sv
// Self-checking bench for tpu_ctrl: directed jobs plus a per-cycle transfer-level model.
// Define TPU_CTRL_PERF_EN to also exercise the performance counters.
module tb_tpu_ctrl;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 8;
    localparam int DIM_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i;
    logic [DIM_W-1:0]  m_i, n_i, k_i;
    logic              busy, done;
    logic [ADDR_W-1:0] gbuf_rd_idx;
    logic [WORD_W-1:0] gbuf_a_dout, gbuf_b_dout;
    logic              tpu_start;
    logic [DIM_W-1:0]  tpu_n;
    logic              tpu_in_valid;
    logic              tpu_in_ready = 1'b0;
    logic [WORD_W-1:0] tpu_a, tpu_b;
    logic              tpu_out_valid = 1'b0;
    logic              tpu_out_ready;
    logic [WORD_W-1:0] tpu_out = 32'hDEAD_BEEF;
    logic              gbuf_o_wr_en;
    logic [ADDR_W-1:0] gbuf_o_idx;
    logic [WORD_W-1:0] gbuf_o_din;
`ifdef TPU_CTRL_PERF_EN
    logic [31:0]       perf_cycles, perf_stall;
`endif

    always #5 clk = ~clk;

    assign gbuf_a_dout = 32'hA000_0000 | 32'(gbuf_rd_idx);
    assign gbuf_b_dout = 32'hB000_0000 | 32'(gbuf_rd_idx);

    tpu_ctrl #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .m_i             (m_i),
        .n_i             (n_i),
        .k_i             (k_i),
        .busy_o          (busy),
        .done_o          (done),
        .gbuf_rd_idx_o   (gbuf_rd_idx),
        .gbuf_a_dout_i   (gbuf_a_dout),
        .gbuf_b_dout_i   (gbuf_b_dout),
        .tpu_start_o     (tpu_start),
        .tpu_n_o         (tpu_n),
        .tpu_in_valid_o  (tpu_in_valid),
        .tpu_in_ready_i  (tpu_in_ready),
        .tpu_a_o         (tpu_a),
        .tpu_b_o         (tpu_b),
        .tpu_out_valid_i (tpu_out_valid),
        .tpu_out_ready_o (tpu_out_ready),
        .tpu_out_i       (tpu_out),
        .gbuf_o_wr_en_o  (gbuf_o_wr_en),
        .gbuf_o_idx_o    (gbuf_o_idx),
`ifdef TPU_CTRL_PERF_EN
        .perf_cycles_o   (perf_cycles),
        .perf_stall_o    (perf_stall),
`endif
        .gbuf_o_din_o    (gbuf_o_din)
    );

    int          assertCount = 0;
    int          failCount = 0;
    int          cyc = 0;
    bit          mActive = 0;
    int          mM = 0, mN = 0, mK = 0, mRd = 0, mWr = 0;
    int          doneCount = 0, lastStartCyc = 0, lastDoneCyc = 0;
    int          hsTotal = 0, wrTotal = 0, validTotal = 0, stallTotal = 0;
    int          jobId = 0;
    logic [31:0] outMem [256];
    logic [31:0] readyPat = '1;
    logic [31:0] validPat = '1;
    bit          outValidAlways = 0;
    int          rdSlot = 0, wrSlot = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    always @(posedge clk) cyc++;

    // tpu/GBUFF stand-in: ready and result-valid follow per-job bit patterns, one bit per cycle.
    always @(posedge clk) begin
        #1;
        if (tpu_in_valid) begin
            tpu_in_ready = readyPat[rdSlot];
            if (rdSlot < 31) rdSlot++;
        end else begin
            tpu_in_ready = 1'b0;
            rdSlot = 0;
        end
        if (tpu_out_ready) begin
            tpu_out_valid = outValidAlways | validPat[wrSlot];
            if (wrSlot < 31) wrSlot++;
        end else begin
            tpu_out_valid = outValidAlways;
            wrSlot = 0;
        end
        tpu_out = tpu_out_valid ? {16'hD000 + 16'(jobId), 16'(mWr)} : 32'hDEAD_BEEF;
    end

    // Transfer-level model: every read must be the next index, every write the next result slot.
    always @(negedge clk) begin
        if (!rst_n) begin
            mActive = 0;
            mRd = 0;
            mWr = 0;
        end else begin
            if (mActive) checkOutput("busy_during_job", busy, 1);
            else if (!tpu_start) checkOutput("idle_quiet", {busy, done, tpu_in_valid, tpu_out_ready}, 0);
            if (tpu_start) begin
                checkOutput("start_only_idle", mActive, 0);
                mActive = 1;
                mM = m_i; mN = n_i; mK = k_i;
                mRd = 0; mWr = 0;
                lastStartCyc = cyc;
            end else if (mActive) begin
                checkOutput("tpu_n", tpu_n, mN);
            end
            if (tpu_in_valid) begin
                validTotal++;
                checkOutput("rd_in_range", mRd < mK, 1);
                checkOutput("rd_idx", gbuf_rd_idx, mRd);
                checkOutput("tpu_a", tpu_a, 32'hA000_0000 | mRd);
                checkOutput("tpu_b", tpu_b, 32'hB000_0000 | mRd);
                if (tpu_in_ready) begin mRd++; hsTotal++; end
                else stallTotal++;
            end else begin
                checkOutput("operands_zero", tpu_a | tpu_b, 0);
            end
            if (tpu_out_ready) begin
                checkOutput("rd_complete_before_wr", mRd, mK);
                if (!tpu_out_valid) stallTotal++;
            end
            checkOutput("wr_strobe", gbuf_o_wr_en, tpu_out_valid && tpu_out_ready);
            if (gbuf_o_wr_en) begin
                checkOutput("wr_in_range", mWr < mM, 1);
                checkOutput("wr_idx", gbuf_o_idx, mWr);
                checkOutput("wr_data", gbuf_o_din, tpu_out);
                outMem[gbuf_o_idx] = gbuf_o_din;
                mWr++;
                wrTotal++;
            end else begin
                checkOutput("din_zero", gbuf_o_din, 0);
            end
            if (done) begin
                checkOutput("done_in_job", mActive, 1);
                checkOutput("reads_at_done", mRd, (mM == 0 || mK == 0) ? 0 : mK);
                checkOutput("writes_at_done", mWr, (mM == 0 || mK == 0) ? 0 : mM);
                doneCount++;
                lastDoneCyc = cyc;
                mActive = 0;
            end
        end
    end

    task automatic applyStimulus(input int m, input int n, input int k);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        m_i = DIM_W'(m); n_i = DIM_W'(n); k_i = DIM_W'(k);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        m_i = DIM_W'($urandom); n_i = DIM_W'($urandom); k_i = DIM_W'($urandom);
    endtask

    task automatic waitDone(input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        checkOutput("done_seen", got, 1);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  d0, h0, w0, v0, s0, lat;
        bit  got;
        start_i = 0; m_i = 0; n_i = 0; k_i = 0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ctrl", {busy, done, tpu_start, tpu_in_valid, tpu_out_ready, gbuf_o_wr_en}, 0);
        checkOutput("reset_data", gbuf_rd_idx | gbuf_o_idx | tpu_a | gbuf_o_din | tpu_n, 0);
        rst_n = 1'b1;

        $display("[TB] job 1: m=4 n=4 k=4, results valid 3 cycles after WAIT");
        jobId = 1; readyPat = '1; validPat = 32'hFFFF_FFFC;
        d0 = doneCount; h0 = hsTotal; w0 = wrTotal;
        applyStimulus(4, 4, 4);
        waitDone(100);
        checkOutput("t1_latency", lastDoneCyc - lastStartCyc, 12);
        checkOutput("t1_reads", hsTotal - h0, 4);
        checkOutput("t1_writes", wrTotal - w0, 4);
        checkOutput("t1_done_once", doneCount - d0, 1);
        checkOutput("t1_out0", outMem[0], 32'hD001_0000);
        checkOutput("t1_out3", outMem[3], 32'hD001_0003);
        @(negedge clk);
        checkOutput("t1_busy_after_done", busy, 0);

        $display("[TB] job 2: k=8 with alternating ready, results offered early");
        jobId = 2; readyPat = 32'h5555_5555; validPat = '0; outValidAlways = 1;
        h0 = hsTotal; w0 = wrTotal; s0 = stallTotal;
        applyStimulus(2, 3, 8);
        waitDone(200);
        outValidAlways = 0;
        checkOutput("t2_latency", lastDoneCyc - lastStartCyc, 19);
        checkOutput("t2_reads", hsTotal - h0, 8);
        checkOutput("t2_writes", wrTotal - w0, 2);
        checkOutput("t2_stalls", stallTotal - s0, 7);
        checkOutput("t2_out1", outMem[1], 32'hD002_0001);

        $display("[TB] job 3: zero dimensions");
        jobId = 3; readyPat = '1; validPat = '1;
        v0 = validTotal; w0 = wrTotal;
        applyStimulus(3, 2, 0);
        waitDone(10);
        checkOutput("t3_k0_latency", lastDoneCyc - lastStartCyc, 1);
        applyStimulus(0, 2, 5);
        waitDone(10);
        checkOutput("t3_m0_latency", lastDoneCyc - lastStartCyc, 1);
        checkOutput("t3_no_valid", validTotal - v0, 0);
        checkOutput("t3_no_writes", wrTotal - w0, 0);

        $display("[TB] job 4: start held high, dims changed after acceptance");
        jobId = 4; w0 = wrTotal;
        @(posedge clk);
        #1;
        start_i = 1'b1; m_i = 5'd2; n_i = 5'd1; k_i = 5'd2;
        @(posedge clk);
        #1;
        m_i = 5'd3; n_i = 5'd7; k_i = 5'd1;
        waitDone(100);
        checkOutput("t4_job1_latency", lastDoneCyc - lastStartCyc, 6);
        checkOutput("t4_job1_writes", wrTotal - w0, 2);
        d0 = lastDoneCyc; w0 = wrTotal;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (tpu_start) got = 1;
        end
        checkOutput("t4_restart_seen", got, 1);
        #1;
        checkOutput("t4_restart_gap", lastStartCyc - d0, 1);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        waitDone(100);
        checkOutput("t4_job2_latency", lastDoneCyc - lastStartCyc, 6);
        checkOutput("t4_job2_writes", wrTotal - w0, 3);

        $display("[TB] job 5: reset asserted mid-read");
        jobId = 5; readyPat = '1;
        applyStimulus(4, 1, 8);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (tpu_in_valid && gbuf_rd_idx == 8'd3) got = 1;
        end
        checkOutput("t5_reached_idx3", got, 1);
        d0 = doneCount;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_async_ctrl", {busy, done, tpu_start, tpu_in_valid, tpu_out_ready, gbuf_o_wr_en}, 0);
        checkOutput("t5_async_data", gbuf_rd_idx | gbuf_o_idx | tpu_a | tpu_b | gbuf_o_din | tpu_n, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        checkOutput("t5_no_done_pulse", doneCount - d0, 0);
        h0 = hsTotal;
        applyStimulus(1, 1, 2);
        waitDone(50);
        checkOutput("t5_latency", lastDoneCyc - lastStartCyc, 5);
        checkOutput("t5_reads", hsTotal - h0, 2);

`ifdef TPU_CTRL_PERF_EN
        $display("[TB] job 6: performance counters");
        jobId = 6; readyPat = 32'hFFFF_FFF5; validPat = 32'hFFFF_FFFD;
        s0 = stallTotal;
        applyStimulus(2, 2, 4);
        waitDone(100);
        lat = lastDoneCyc - lastStartCyc;
        checkOutput("t6_latency", lat, 11);
        @(negedge clk);
        checkOutput("t6_perf_cycles", perf_cycles, 12);
        checkOutput("t6_perf_stall", perf_stall, 3);
        checkOutput("t6_perf_cycles_model", perf_cycles, lat + 1);
        checkOutput("t6_perf_stall_model", perf_stall, stallTotal - s0);
        repeat (3) @(negedge clk);
        checkOutput("t6_perf_hold", perf_cycles, 12);
`else
        lat = 0;
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
